// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_responder
//  Description : Direct-mapped, write-back, write-allocate data cache between
//                the pipeline MEM stage and a 128-bit block memory. Hits are
//                served with zero stall; misses stall until the line is
//                refilled (after a write-back when the victim is dirty).
//                Optional feature macro: DCACHE_PERF_CNT_EN adds the
//                hit_cnt / miss_cnt performance counter outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_responder #(
    parameter int INDEX_W    = 3,
    parameter int ADDR_W     = 30,
    parameter int BLK_ADDR_W = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  proc_ren,
    input  logic                  proc_wen,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [31:0]           proc_wdata,
    output logic [31:0]           proc_rdata,
    output logic                  proc_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BLK_ADDR_W-1:0] mem_addr,
    output logic [127:0]          mem_wdata,
    input  logic [127:0]          mem_rdata,
    input  logic                  mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int c_LINES = 2 ** INDEX_W;
    localparam int c_TAG_W = ADDR_W - 2 - INDEX_W;

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_LINES-1:0]      r_valid;
    logic [c_LINES-1:0]      r_dirty;
    logic [c_TAG_W-1:0]      r_tag  [c_LINES];
    logic [127:0]            r_data [c_LINES];
    // Block address of the miss being serviced; survives a dropped request.
    logic [BLK_ADDR_W-1:0]   r_miss_addr;

    logic [INDEX_W-1:0]      w_idx;
    logic [c_TAG_W-1:0]      w_tag;
    logic [1:0]              w_off;
    logic                    w_req;
    logic                    w_hit;
    logic [127:0]            w_line;
    logic [31:0]             w_word;
    logic [INDEX_W-1:0]      w_miss_idx;
    logic [c_TAG_W-1:0]      w_miss_tag;

    assign w_off      = proc_addr[1:0];
    assign w_idx      = proc_addr[INDEX_W+1:2];
    assign w_tag      = proc_addr[ADDR_W-1:INDEX_W+2];
    assign w_req      = proc_ren | proc_wen;
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line     = r_data[w_idx];
    assign w_word     = w_line[{w_off, 5'b0} +: 32];
    assign w_miss_idx = r_miss_addr[INDEX_W-1:0];
    assign w_miss_tag = r_miss_addr[BLK_ADDR_W-1:INDEX_W];

    // A request stalls unless it hits while the controller is idle-comparing.
    assign proc_stall = w_req && !((r_state == S_COMPARE) && w_hit);
    // Write has priority, so read data is only driven for a pure read.
    assign proc_rdata = (proc_ren && !proc_wen) ? w_word : 32'd0;

    // Controller FSM with registered memory-side outputs and line status bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_COMPARE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_miss_addr <= '0;
        end else begin
            case (r_state)
                S_COMPARE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (proc_wen) begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else begin
                            r_miss_addr <= proc_addr[ADDR_W-1:2];
                            if (r_valid[w_idx] && r_dirty[w_idx]) begin
                                r_state   <= S_WRITEBACK;
                                mem_write <= 1'b1;
                                mem_addr  <= {r_tag[w_idx], w_idx};
                                mem_wdata <= w_line;
                            end else begin
                                r_state  <= S_ALLOCATE;
                                mem_read <= 1'b1;
                                mem_addr <= proc_addr[ADDR_W-1:2];
                            end
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ready) begin
                        r_state   <= S_ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= r_miss_addr;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ready) begin
                        r_state             <= S_COMPARE;
                        mem_read            <= 1'b0;
                        r_valid[w_miss_idx] <= 1'b1;
                        r_dirty[w_miss_idx] <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_COMPARE;
                end
            endcase
        end
    end

    // Tag and data storage: refill writes the whole line, write hits one word.
    always_ff @(posedge clk) begin
        if ((r_state == S_ALLOCATE) && mem_ready) begin
            r_data[w_miss_idx] <= mem_rdata;
            r_tag[w_miss_idx]  <= w_miss_tag;
        end else if ((r_state == S_COMPARE) && proc_wen && w_hit) begin
            r_data[w_idx][{w_off, 5'b0} +: 32] <= proc_wdata;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Performance counters: served hits per cycle and misses per FSM departure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if ((r_state == S_COMPARE) && w_req) begin
            if (w_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_responder
//  Description : Self-checking bench for dcache_responder. A behavioural
//                block memory answers refills/write-backs with a randomised
//                delay; a word-level reference image feeds a queue of
//                expected read data that is popped when each read completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_responder;

    logic         clk;
    logic         rst;
    logic         proc_ren;
    logic         proc_wen;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    dcache_responder dut (
        .clk        (clk),
        .rst        (rst),
        .proc_ren   (proc_ren),
        .proc_wen   (proc_wen),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory image and reference model ----------------
    logic [127:0] bmem    [int];
    logic [31:0]  ref_mem [int];
    logic [31:0]  exp_q   [$];
    logic         log_wr    [$];
    logic [27:0]  log_addr  [$];
    logic [127:0] log_wdata [$];

    int busy      = 0;
    int min_delay = 0;
    int max_delay = 0;

    function automatic logic [31:0] init_word(input int a);
        if (a == 4) return 32'hDEAD_BEEF;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] blk_read(input int b);
        if (bmem.exists(b)) return bmem[b];
        return {init_word(4*b+3), init_word(4*b+2), init_word(4*b+1), init_word(4*b)};
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        logic [127:0] blk;
        if (ref_mem.exists(a)) return ref_mem[a];
        blk = blk_read(a >> 2);
        return blk[(a & 3) * 32 +: 32];
    endfunction

    // Behavioural block memory: one ready pulse per request after a random delay.
    initial begin
        bit          pend;
        bit          cur_rd;
        logic [27:0] cur_addr;
        int          wait_left;
        pend = 0; cur_rd = 0; cur_addr = '0; wait_left = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst || !(mem_read || mem_write)) begin
                pend = 0;
            end else begin
                busy++;
                check_val("mem_exclusive", mem_read & mem_write, 1'b0);
                if (!pend) begin
                    pend      = 1;
                    cur_rd    = mem_read;
                    cur_addr  = mem_addr;
                    wait_left = $urandom_range(max_delay, min_delay);
                    log_wr.push_back(mem_write);
                    log_addr.push_back(mem_addr);
                    log_wdata.push_back(mem_wdata);
                end else begin
                    check_val("mem_hold", {mem_read, mem_write, mem_addr}, {cur_rd, ~cur_rd, cur_addr});
                end
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    if (cur_rd) mem_rdata = blk_read(int'(mem_addr));
                    else        bmem[int'(mem_addr)] = mem_wdata;
                    pend = 0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Issue one request at a negedge; exp_miss: 0 hit, 1 miss, -1 unknown.
    task automatic do_req(input logic r, input logic w, input logic [29:0] a,
                          input logic [31:0] d, input int exp_miss);
        int n;
        int b0;
        proc_ren = r; proc_wen = w; proc_addr = a; proc_wdata = d;
        if (w) ref_mem[int'(a)] = d;
        else if (r) exp_q.push_back(ref_read(int'(a)));
        #1;
        b0 = busy;
        n  = 0;
        if (exp_miss == 0) check_val("hit_no_stall", proc_stall, 1'b0);
        if (exp_miss == 1) check_val("miss_stall", proc_stall, 1'b1);
        while (proc_stall && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (proc_stall) begin
            check_val("req_timeout", proc_stall, 1'b0);
        end else begin
            if (n != 0) check_val("miss_latency", 128'(n), 128'(1 + busy - b0));
            if (r && !w) check_val("rdata", proc_rdata, exp_q.pop_front());
        end
        @(negedge clk);
        proc_ren = 1'b0; proc_wen = 1'b0;
    endtask

    task automatic clear_log();
        log_wr.delete(); log_addr.delete(); log_wdata.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; proc_ren = 1'b0; proc_wen = 1'b0; proc_addr = '0; proc_wdata = '0;
        #12;
        check_val("rst_stall", proc_stall, 1'b0);
        check_val("rst_rdata", proc_rdata, 32'd0);
        check_val("rst_mem_rw", {mem_read, mem_write}, 2'b00);
        check_val("rst_mem_addr", mem_addr, 28'd0);
        check_val("rst_mem_wdata", mem_wdata, 128'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Cold read miss, then hit on the retry.
        clear_log();
        do_req(1'b1, 1'b0, 30'h4, 32'd0, 1);
        check_val("t1_log_n", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check_val("t1_mem_addr", log_addr[0], 28'h1);
            check_val("t1_is_read", log_wr[0], 1'b0);
        end

        // Write hit then read hit, no memory traffic.
        clear_log();
        do_req(1'b0, 1'b1, 30'h5, 32'h1234_5678, 0);
        do_req(1'b1, 1'b0, 30'h5, 32'd0, 0);
        check_val("t2_log_n", log_addr.size(), 0);

        // Conflict miss on dirty line: write-back then refill.
        clear_log();
        do_req(1'b1, 1'b0, 30'h24, 32'd0, 1);
        check_val("t3_log_n", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check_val("t3_wb_is_write", log_wr[0], 1'b1);
            check_val("t3_wb_addr", log_addr[0], 28'h1);
            check_val("t3_wb_word1", log_wdata[0][63:32], 32'h1234_5678);
            check_val("t3_rf_is_read", log_wr[1], 1'b0);
            check_val("t3_rf_addr", log_addr[1], 28'h9);
        end
`ifdef DCACHE_PERF_CNT_EN
        check_val("hit_cnt", hit_cnt, 32'd4);
        check_val("miss_cnt", miss_cnt, 32'd2);
`endif

        // Random traffic with stretched memory latency.
        min_delay = 0; max_delay = 10;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 1);
            do_req(k[0], ~k[0], 30'($urandom_range(0, 127)), $urandom, -1);
        end

        // Reset in the middle of a refill.
        min_delay = 8; max_delay = 8;
        proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h140;
        k = 0;
        while (!mem_read && k < 50) begin @(negedge clk); k++; end
        check_val("t5_mem_read_seen", mem_read, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_val("t5_rst_mem_read", mem_read, 1'b0);
        check_val("t5_rst_mem_write", mem_write, 1'b0);
        check_val("t5_rst_mem_addr", mem_addr, 28'd0);
        proc_ren = 1'b0;
        ref_mem.delete();
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        min_delay = 0; max_delay = 3;
        @(negedge clk);
        do_req(1'b1, 1'b0, 30'h140, 32'd0, 1);
        do_req(1'b1, 1'b0, 30'h5, 32'd0, 1);
        do_req(1'b1, 1'b0, 30'h140, 32'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
